// File: rtl/vga_timing_out.sv
// -----------------------------------------------------------------------------
// vga_timing_out
//   Pixel-clock VGA timing generator and output stage. Produces the pixel
//   coordinates and draw enable that feed the drawing objects, then takes the
//   muxed 8-bit RRRGGGBB colour that comes back PIPE_DELAY cycles later and
//   drives the 4:4:4 DAC pins plus HS/VS. Sync and blank are run through a
//   PIPE_DELAY-stage delay line so that every pin output is mutually aligned.
//
// Ports
//   clk          in   pixel clock
//   resetN       in   async active-low reset
//   RGBIn        in   [7:0] muxed colour {R[2:0],G[2:0],B[1:0]}, valid
//                     PIPE_DELAY cycles after the matching pixelX/pixelY
//   pixelX       out  [10:0] horizontal count 0..H_TOTAL-1
//   pixelY       out  [10:0] vertical count 0..V_TOTAL-1
//   drawEnable   out  pixel is inside the active area (same cycle as pixelX/Y)
//   startOfFrame out  one-cycle pulse when the counters wrap to (0,0)
//   vgaR/G/B     out  [3:0] DAC colour, registered, zero while blanked
//   vgaHS/vgaVS  out  sync, registered, active level SYNC_POL
//   vgaBlank     out  1 outside the active area, aligned with vgaR/G/B
// -----------------------------------------------------------------------------
module vga_timing_out #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter int   PIPE_DELAY = 2,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        drawEnable,
    output logic        startOfFrame,
    output logic [3:0]  vgaR,
    output logic [3:0]  vgaG,
    output logic [3:0]  vgaB,
    output logic        vgaHS,
    output logic        vgaVS,
    output logic        vgaBlank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Counters and frame pulse
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        sof_q, sof_d;

    // Raw per-pixel timing, derived from the counters only
    logic hs_act, vs_act, blank_raw, draw_en;

    // Delay line: stage 0 is one cycle behind the counters
    logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DELAY-1:0] blank_pipe_q, blank_pipe_d;

    // Output register
    logic [3:0] vga_r_q, vga_r_d;
    logic [3:0] vga_g_q, vga_g_d;
    logic [3:0] vga_b_q, vga_b_d;
    logic       hs_out_q, hs_out_d;
    logic       vs_out_q, vs_out_d;
    logic       blank_out_q, blank_out_d;

    logic hs_dly, vs_dly, blank_dly;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
        end
        // Registered, so it is high exactly while the counters read (0,0)
        // after a real wrap; reset release alone never produces a pulse.
        sof_d = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    end

    assign draw_en   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign hs_act    = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    assign vs_act    = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    assign blank_raw = ~draw_en;

    always_comb begin
        hs_pipe_d       = hs_pipe_q;
        vs_pipe_d       = vs_pipe_q;
        blank_pipe_d    = blank_pipe_q;
        hs_pipe_d[0]    = hs_act;
        vs_pipe_d[0]    = vs_act;
        blank_pipe_d[0] = blank_raw;
        for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe_d[i]    = hs_pipe_q[i-1];
            vs_pipe_d[i]    = vs_pipe_q[i-1];
            blank_pipe_d[i] = blank_pipe_q[i-1];
        end
    end

    assign hs_dly    = hs_pipe_q[PIPE_DELAY-1];
    assign vs_dly    = vs_pipe_q[PIPE_DELAY-1];
    assign blank_dly = blank_pipe_q[PIPE_DELAY-1];

    always_comb begin
        blank_out_d = blank_dly;
        hs_out_d    = hs_dly ? SYNC_POL : ~SYNC_POL;
        vs_out_d    = vs_dly ? SYNC_POL : ~SYNC_POL;
        vga_r_d     = '0;
        vga_g_d     = '0;
        vga_b_d     = '0;
        if (!blank_dly) begin
            // Replicate the MSBs so full-scale 3/2-bit codes reach 4'hF.
            vga_r_d = {RGBIn[7:5], RGBIn[7]};
            vga_g_d = {RGBIn[4:2], RGBIn[4]};
            vga_b_d = {RGBIn[1:0], RGBIn[1:0]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the delay line
    // shift one stage per clock instead of collapsing.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            sof_q        <= 1'b0;
            // NOTE: the delay line is reset too (unlike a data buffer) because
            // its contents reach the sync/blank pins directly after release.
            hs_pipe_q    <= '0;
            vs_pipe_q    <= '0;
            blank_pipe_q <= '1;
            vga_r_q      <= '0;
            vga_g_q      <= '0;
            vga_b_q      <= '0;
            hs_out_q     <= ~SYNC_POL;
            vs_out_q     <= ~SYNC_POL;
            blank_out_q  <= 1'b1;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            sof_q        <= sof_d;
            hs_pipe_q    <= hs_pipe_d;
            vs_pipe_q    <= vs_pipe_d;
            blank_pipe_q <= blank_pipe_d;
            vga_r_q      <= vga_r_d;
            vga_g_q      <= vga_g_d;
            vga_b_q      <= vga_b_d;
            hs_out_q     <= hs_out_d;
            vs_out_q     <= vs_out_d;
            blank_out_q  <= blank_out_d;
        end
    end

    assign pixelX       = h_cnt_q;
    assign pixelY       = v_cnt_q;
    assign drawEnable   = draw_en;
    assign startOfFrame = sof_q;
    assign vgaR         = vga_r_q;
    assign vgaG         = vga_g_q;
    assign vgaB         = vga_b_q;
    assign vgaHS        = hs_out_q;
    assign vgaVS        = vs_out_q;
    assign vgaBlank     = blank_out_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_out
//   Instance u_a uses the full 640x480 timing (line-level checks, colour
//   table). Instance u_b uses a tiny 32x19 raster so whole frames, vertical
//   sync, frame pulses, alignment and mid-frame reset fit in a short run.
//   Outputs are sampled on the falling edge; cycle n after reset release is
//   the n-th falling edge, where the counters read pixel n and the pins show
//   pixel n-3 (PIPE_DELAY 2 + output register).
// -----------------------------------------------------------------------------
module tb_vga_timing_out;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rgb_a, rgb_b;

    logic [10:0] px_a, py_a, px_b, py_b;
    logic        de_a, sof_a, hs_a, vs_a, bl_a;
    logic        de_b, sof_b, hs_b, vs_b, bl_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    always #20 clk = ~clk;

    vga_timing_out u_a (
        .clk(clk), .resetN(rst_n), .RGBIn(rgb_a),
        .pixelX(px_a), .pixelY(py_a), .drawEnable(de_a), .startOfFrame(sof_a),
        .vgaR(r_a), .vgaG(g_a), .vgaB(b_a),
        .vgaHS(hs_a), .vgaVS(vs_a), .vgaBlank(bl_a)
    );

    vga_timing_out #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIPE_DELAY(2), .SYNC_POL(1'b0)
    ) u_b (
        .clk(clk), .resetN(rst_n), .RGBIn(rgb_b),
        .pixelX(px_b), .pixelY(py_b), .drawEnable(de_b), .startOfFrame(sof_b),
        .vgaR(r_b), .vgaG(g_b), .vgaB(b_b),
        .vgaHS(hs_b), .vgaVS(vs_b), .vgaBlank(bl_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] rgb;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } colour_vec_t;

    colour_vec_t vecs[7];

    // Alignment stimulus for u_b: RGBIn = pixelX delayed two cycles.
    logic        align_mode = 1'b0;
    logic [10:0] hist0 = '0, hist1 = '0, hist2 = '0;

    initial begin
        forever begin
            @(negedge clk);
            hist2 = hist1;
            hist1 = hist0;
            hist0 = px_b;
            if (align_mode) rgb_b = hist2[7:0];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_a_pins"}, {hs_a, vs_a, bl_a, r_a, g_a, b_a}, {3'b111, 12'h000});
        check({tag, "_a_pix"},  {px_a, py_a, sof_a}, {11'd0, 11'd0, 1'b0});
        check({tag, "_b_pins"}, {hs_b, vs_b, bl_b, r_b, g_b, b_b}, {3'b111, 12'h000});
        check({tag, "_b_pix"},  {px_b, py_b, sof_b}, {11'd0, 11'd0, 1'b0});
    endtask

    initial begin
        int a_hs_first, a_hs_low, a_vs_low, a_bl_low, a_mask_bad, a_de_cnt;
        int b_hs_low, b_vs_first, b_vs_low, b_bl_low, b_mask_bad;
        int a_px_max, b_px_max, b_py_max;
        int sof_times[$];
        int col, lines_full;
        bit synced, found;
        int sof_first, sof_cnt;
        logic [7:0]  v;
        logic [11:0] exp_rgb;

        vecs[0] = '{8'hE0, 4'hF, 4'h0, 4'h0};
        vecs[1] = '{8'h1C, 4'h0, 4'hF, 4'h0};
        vecs[2] = '{8'h03, 4'h0, 4'h0, 4'hF};
        vecs[3] = '{8'h92, 4'h9, 4'h9, 4'hA};
        vecs[4] = '{8'hFF, 4'hF, 4'hF, 4'hF};
        vecs[5] = '{8'h00, 4'h0, 4'h0, 4'h0};
        vecs[6] = '{8'h49, 4'h4, 4'h4, 4'h5};

        // Reset held with white input: pins must still be blank/inactive.
        rst_n = 1'b0;
        rgb_a = 8'hFF;
        rgb_b = 8'hFF;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        rst_n = 1'b1;

        a_hs_first = -1; a_hs_low = 0; a_vs_low = 0; a_bl_low = 0; a_mask_bad = 0;
        a_de_cnt = 0; b_hs_low = 0; b_vs_first = -1; b_vs_low = 0; b_bl_low = 0;
        b_mask_bad = 0; a_px_max = 0; b_px_max = 0; b_py_max = 0;

        for (int n = 1; n <= 1300; n++) begin
            @(negedge clk);
            if (n <= 800) begin
                if (!hs_a) begin
                    a_hs_low++;
                    if (a_hs_first < 0) a_hs_first = n;
                end
                if (!vs_a) a_vs_low++;
                if (de_a) a_de_cnt++;
                if (!bl_a) begin
                    a_bl_low++;
                    if ({r_a, g_a, b_a} !== 12'hFFF) a_mask_bad++;
                end else if ({r_a, g_a, b_a} !== 12'h000) a_mask_bad++;
                if (int'(px_a) > a_px_max) a_px_max = int'(px_a);
            end
            if (sof_b) sof_times.push_back(n);
            if (int'(px_b) > b_px_max) b_px_max = int'(px_b);
            if (int'(py_b) > b_py_max) b_py_max = int'(py_b);
            if (n <= 32 && !hs_b) b_hs_low++;
            if (n <= 608) begin
                if (!vs_b) begin
                    b_vs_low++;
                    if (b_vs_first < 0) b_vs_first = n;
                end
                if (!bl_b) b_bl_low++;
            end
            if (bl_b && {r_b, g_b, b_b} !== 12'h000) b_mask_bad++;
            if (!bl_b && {r_b, g_b, b_b} !== 12'hFFF) b_mask_bad++;
        end

        // Full-size line: sync falls at 656+3, lasts 96, 640 visible pixels.
        check("a_hs_first_low", a_hs_first, 659);
        check("a_hs_low_cycles", a_hs_low, 96);
        check("a_vs_low_line0", a_vs_low, 0);
        check("a_blank_low_cycles", a_bl_low, 640);
        check("a_draw_enable_cycles", a_de_cnt, 640);
        check("a_blank_masking", a_mask_bad, 0);
        check("a_pixelx_max", a_px_max, 799);

        // Small raster: 32x19 = 608 cycles/frame, vsync on lines 14..15.
        check("b_sof_count", sof_times.size(), 2);
        if (sof_times.size() >= 2) begin
            check("b_sof_first", sof_times[0], 608);
            check("b_sof_period", sof_times[1] - sof_times[0], 608);
        end
        check("b_pixelx_max", b_px_max, 31);
        check("b_pixely_max", b_py_max, 18);
        check("b_hs_low_cycles", b_hs_low, 8);
        check("b_vs_first_low", b_vs_first, 451);
        check("b_vs_low_cycles", b_vs_low, 64);
        check("b_blank_low_frame", b_bl_low, 192);
        check("b_blank_masking", b_mask_bad, 0);

        // Colour expansion table on the full-size instance, mid line 1.
        align_mode = 1'b1;
        foreach (vecs[i]) begin
            rgb_a = vecs[i].rgb;
            repeat (4) @(negedge clk);
            check($sformatf("colour_blank_%02h", vecs[i].rgb), bl_a, 1'b0);
            check($sformatf("colour_rgb_%02h", vecs[i].rgb), {r_a, g_a, b_a},
                  {vecs[i].r, vecs[i].g, vecs[i].b});
        end

        // Alignment: each visible pin pixel must decode from its own column.
        col = 0; synced = 1'b0; lines_full = 0;
        for (int n = 0; n < 96; n++) begin
            @(negedge clk);
            if (bl_b) begin
                if (synced && col == 16) lines_full++;
                synced = 1'b1;
                col = 0;
            end else if (synced) begin
                v = 8'(col);
                exp_rgb = {v[7:5], v[7], v[4:2], v[4], v[1:0], v[1:0]};
                check($sformatf("align_col%0d", col), {r_b, g_b, b_b}, exp_rgb);
                col++;
            end
        end
        check("align_full_lines_seen", (lines_full >= 1) ? 1 : 0, 1);

        // Mid-frame reset on u_b at pixel (5,3).
        found = 1'b0;
        for (int n = 0; n < 1000 && !found; n++) begin
            @(negedge clk);
            if (px_b == 11'd5 && py_b == 11'd3) found = 1'b1;
        end
        check("wait_pixel_5_3", found, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sof_first = -1; sof_cnt = 0;
        for (int n = 1; n <= 700; n++) begin
            @(negedge clk);
            if (n == 1) check("restart_pixel", {px_b, py_b}, {11'd1, 11'd0});
            if (sof_b) begin
                sof_cnt++;
                if (sof_first < 0) sof_first = n;
            end
        end
        check("restart_sof_first", sof_first, 608);
        check("restart_sof_count", sof_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
